ftdi_rx_reader: RTL

FT600-class 245-synchronous-FIFO read master: host-to-FPGA direction of the FTDI bus, paired with the existing write path. Runs entirely in the FTDI 100 MHz clock domain. Watches RXF_N and drives OE_N/RD_N to burst words off the 32-bit DATA / 4-bit BE bus into an internal FWFT FIFO, then presents them downstream on a valid/ready stream. Top level tristates DATA/BE using bus_rd_out.

---
 rtl/ftdi_pkg.sv | 35 +++
 rtl/sync_fwft_fifo.sv | 59 +++++
 rtl/ftdi_rx_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT600 245-sync FIFO read path.
// Also maps FSM states to their pin levels.
package ftdi_pkg;

  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W   = 4;
  localparam int FT_WORD_W = 36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TURN    = 2'd1,
    ST_READ    = 2'd2,
    ST_RELEASE = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [FT_BE_W-1:0]   be;
    logic [FT_DATA_W-1:0] data;
  } ft_word_t;

  // Pin levels {oe_n, rd_n, bus_rd} for a given state.
  function automatic logic [2:0] pins_of(rx_state_e s);
    logic [2:0] p;
    p = 3'b110;
    unique case (s)
      ST_IDLE:    p = 3'b110;
      ST_TURN:    p = 3'b011;
      ST_READ:    p = 3'b001;
      ST_RELEASE: p = 3'b111;
      default:    p = 3'b110;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Head entry is visible on rd_data whenever empty is low.
module sync_fwft_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is only taken if a read frees a slot.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/ftdi_rx_reader.sv
// FT600 read master: bursts host words off the bus into a FWFT FIFO
// and presents them downstream on a valid/ready stream.
module ftdi_rx_reader
  import ftdi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rxf_n_in,
  input  logic [FT_DATA_W-1:0] data_in,
  input  logic [FT_BE_W-1:0]   be_in,
  output logic                 oe_n_out,
  output logic                 rd_n_out,
  output logic                 bus_rd_out,
  output logic [FT_DATA_W-1:0] data_out,
  output logic [FT_BE_W-1:0]   be_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 overflow_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e     state_q, state_d;
  logic          oe_n_q, oe_n_d;
  logic          rd_n_q, rd_n_d;
  logic          bus_rd_q, bus_rd_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          room_ok;
  logic          start_ok;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  ft_word_t      wr_word;
  ft_word_t      rd_word;

  assign wr_word = '{be: be_in, data: data_in};

  sync_fwft_fifo #(
    .WIDTH(FT_WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_in),
    .rst    (rst_in),
    .wr_en  (push),
    .wr_data(wr_word),
    .rd_en  (pop),
    .rd_data(rd_word),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  // The margin absorbs the word already launched when READ is left.
  always_comb begin
    free     = CW'(FIFO_DEPTH) - count;
    room_ok  = (free >= CW'(AF_MARGIN));
    start_ok = !rxf_n_in && room_ok;
    push     = !oe_n_q && !rd_n_q && !rxf_n_in;
    pop      = !empty && ready_in;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_TURN;
      end
      ST_TURN: begin
        state_d = rxf_n_in ? ST_RELEASE : ST_READ;
      end
      ST_READ: begin
        if (rxf_n_in || !room_ok) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    {oe_n_d, rd_n_d, bus_rd_d} = pins_of(state_d);
    overflow_d = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      bus_rd_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      oe_n_q     <= oe_n_d;
      rd_n_q     <= rd_n_d;
      bus_rd_q   <= bus_rd_d;
      overflow_q <= overflow_d;
    end
  end

  assign oe_n_out     = oe_n_q;
  assign rd_n_out     = rd_n_q;
  assign bus_rd_out   = bus_rd_q;
  assign overflow_out = overflow_q;
  assign valid_out    = !empty;
  assign data_out     = rd_word.data;
  assign be_out       = rd_word.be;

endmodule
